// File: rtl/tdm_demux8_if.sv
// Serial-link side and parallel-channel side of the 8:1 TDM demultiplexer.
//   din, din_valid, sync   : serial slot bit, its qualifier and the slot-0 marker
//   d0..d7                 : last complete frame, one bit per channel
//   s2,s1,s0               : slot expected next (s2 = MSB)
//   locked                 : receiver is aligned to the frame
//   frame_valid, sync_err  : one-cycle event pulses
// master = link/consumer side, slave = the demultiplexer.
interface tdm_demux8_if;
   logic din;
   logic din_valid;
   logic sync;
   logic d0, d1, d2, d3, d4, d5, d6, d7;
   logic s2, s1, s0;
   logic locked;
   logic frame_valid;
   logic sync_err;

   modport master (
      output din, din_valid, sync,
      input  d0, d1, d2, d3, d4, d5, d6, d7,
      input  s2, s1, s0, locked, frame_valid, sync_err
   );

   modport slave (
      input  din, din_valid, sync,
      output d0, d1, d2, d3, d4, d5, d6, d7,
      output s2, s1, s0, locked, frame_valid, sync_err
   );
endinterface

// File: rtl/tdm_demux8.sv
// Receive end of the 8:1 TDM channel mux. Tracks the slot of each valid serial
// bit, assembles a shadow frame and publishes all 8 channels in parallel when
// slot 7 arrives. Drops back to HUNT after IDLE_LIMIT idle cycles while locked.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : tdm_demux8_if.slave (serial input, channel outputs, status)
module tdm_demux8 #(
   parameter int unsigned IDLE_W     = 4,
   parameter int unsigned IDLE_LIMIT = 15
) (
   input  logic          clk,
   input  logic          rst,
   tdm_demux8_if.slave   bus
);

   localparam int unsigned SLOT_W = 3;
   localparam int unsigned FRAME_W = 8;
   localparam bit IDLE_EN = (IDLE_LIMIT != 0);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [SLOT_W-1:0]   slot_q, slot_nxt;
   logic [FRAME_W-1:0]  shadow_q, shadow_nxt;
   logic [FRAME_W-1:0]  dout_q, dout_nxt;
   logic                fv_q, fv_nxt;
   logic                err_q, err_nxt;
   logic [IDLE_W-1:0]   idle_q, idle_nxt;
   logic                idle_hit;

   // Last idle cycle of the allowed gap: this edge drops the lock.
   assign idle_hit = IDLE_EN && (state == LOCKED) && !bus.din_valid && (idle_q == IDLE_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HUNT;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (bus.din_valid && bus.sync) state_nxt = LOCKED;
         LOCKED:  if (idle_hit)                  state_nxt = HUNT;
         default: state_nxt = HUNT;
      endcase
   end

   // Datapath/output next values
   always_comb begin
      slot_nxt   = slot_q;
      shadow_nxt = shadow_q;
      dout_nxt   = dout_q;
      fv_nxt     = 1'b0;
      err_nxt    = 1'b0;
      idle_nxt   = idle_q;
      case (state)
         HUNT: begin
            idle_nxt = '0;
            // Shadow is already clear in HUNT, so loading slot 0 is a full reload.
            if (bus.din_valid && bus.sync) begin
               shadow_nxt = {7'b0, bus.din};
               slot_nxt   = SLOT_W'(1);
            end
         end
         LOCKED: begin
            if (bus.din_valid) begin
               idle_nxt = '0;
               if (bus.sync && (slot_q != '0)) begin
                  // Misaligned sync (including slot 7): drop the partial frame, realign.
                  err_nxt    = 1'b1;
                  shadow_nxt = {7'b0, bus.din};
                  slot_nxt   = SLOT_W'(1);
               end else begin
                  shadow_nxt[slot_q] = bus.din;
                  slot_nxt           = slot_q + SLOT_W'(1);
                  if (slot_q == SLOT_W'(7)) begin
                     // Slot 7 bit goes straight to d7 on the publishing edge.
                     dout_nxt = {bus.din, shadow_q[6:0]};
                     fv_nxt   = 1'b1;
                  end
               end
            end else if (idle_hit) begin
               idle_nxt   = '0;
               slot_nxt   = '0;
               shadow_nxt = '0;
            end else if (idle_q != '1) begin
               idle_nxt = idle_q + IDLE_W'(1);
            end
         end
         default: begin
            idle_nxt = '0;
         end
      endcase
   end

   // Datapath/output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         idle_q   <= '0;
      end else begin
         slot_q   <= slot_nxt;
         shadow_q <= shadow_nxt;
         dout_q   <= dout_nxt;
         fv_q     <= fv_nxt;
         err_q    <= err_nxt;
         idle_q   <= idle_nxt;
      end
   end

   assign bus.d0          = dout_q[0];
   assign bus.d1          = dout_q[1];
   assign bus.d2          = dout_q[2];
   assign bus.d3          = dout_q[3];
   assign bus.d4          = dout_q[4];
   assign bus.d5          = dout_q[5];
   assign bus.d6          = dout_q[6];
   assign bus.d7          = dout_q[7];
   assign bus.s2          = slot_q[2];
   assign bus.s1          = slot_q[1];
   assign bus.s0          = slot_q[0];
   assign bus.locked      = (state == LOCKED);
   assign bus.frame_valid = fv_q;
   assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised and directed bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;

   localparam int unsigned IDLE_W     = 4;
   localparam int unsigned IDLE_LIMIT = 15;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tdm_demux8_if bus ();

   tdm_demux8 #(
      .IDLE_W     (IDLE_W),
      .IDLE_LIMIT (IDLE_LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: bits of the frame in progress, published frame, status.
   bit       frame_q[$];
   bit [7:0] dout_m;
   bit       locked_m;
   bit       fv_m;
   bit       err_m;
   int       idle_m;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] dut_d();
      return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
   endfunction

   task automatic model_reset();
      frame_q.delete();
      dout_m   = '0;
      locked_m = 1'b0;
      fv_m     = 1'b0;
      err_m    = 1'b0;
      idle_m   = 0;
   endtask

   // One clock edge of the frame rules: slot is simply how many bits are held.
   task automatic model_clk(input bit v, input bit s, input bit b);
      fv_m  = 1'b0;
      err_m = 1'b0;
      if (!locked_m) begin
         idle_m = 0;
         if (v && s) begin
            frame_q.delete();
            frame_q.push_back(b);
            locked_m = 1'b1;
         end
      end else if (v) begin
         idle_m = 0;
         if (s && frame_q.size() != 0) begin
            err_m = 1'b1;
            frame_q.delete();
            frame_q.push_back(b);
         end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 8) begin
               for (int k = 0; k < 8; k++) dout_m[k] = frame_q[k];
               fv_m = 1'b1;
               frame_q.delete();
            end
         end
      end else begin
         idle_m++;
         if (IDLE_LIMIT != 0 && idle_m >= int'(IDLE_LIMIT)) begin
            locked_m = 1'b0;
            frame_q.delete();
            idle_m = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".d"},      dut_d(), dout_m);
      check_eq({tag, ".slot"},   {5'b0, bus.s2, bus.s1, bus.s0}, 8'(frame_q.size()));
      check_eq({tag, ".locked"}, {7'b0, bus.locked}, {7'b0, locked_m});
      check_eq({tag, ".fv"},     {7'b0, bus.frame_valid}, {7'b0, fv_m});
      check_eq({tag, ".err"},    {7'b0, bus.sync_err}, {7'b0, err_m});
   endtask

   task automatic step(input bit v, input bit s, input bit b);
      @(negedge clk);
      bus.din_valid = v;
      bus.sync      = s;
      bus.din       = b;
      @(posedge clk);
      model_clk(v, s, b);
      #1;
      check_all("cyc");
   endtask

   task automatic send_frame(input logic [7:0] bits);
      for (int k = 0; k < 8; k++) step(1'b1, k == 0, bits[k]);
   endtask

   initial begin
      bit v, s;
      rst           = 1'b1;
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
      model_reset();

      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.din       = 1'($urandom);
         bus.din_valid = 1'($urandom);
         bus.sync      = 1'($urandom);
         @(posedge clk);
         #1;
         check_all("rst");
      end
      check_eq("rst.d_zero", dut_d(), 8'h00);
      @(negedge clk);
      rst           = 1'b0;
      bus.din_valid = 1'b0;
      step(1'b0, 1'b1, 1'b1);
      check_eq("rst.hunt", {7'b0, bus.locked}, 8'h00);

      // Clean frame
      send_frame(8'h4D);
      check_eq("clean.d",  dut_d(), 8'h4D);
      check_eq("clean.fv", {7'b0, bus.frame_valid}, 8'h01);
      step(1'b0, 1'b0, 1'b0);
      check_eq("clean.fv_pulse", {7'b0, bus.frame_valid}, 8'h00);

      // Walking one, back to back
      for (int k = 0; k < 8; k++) begin
         logic [7:0] pat;
         pat = 8'(1 << k);
         send_frame(pat);
         check_eq("walk.d",  dut_d(), pat);
         check_eq("walk.fv", {7'b0, bus.frame_valid}, 8'h01);
      end

      // Misaligned sync at slot 3
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      check_eq("mis.err",  {7'b0, bus.sync_err}, 8'h01);
      check_eq("mis.slot", {5'b0, bus.s2, bus.s1, bus.s0}, 8'h01);
      check_eq("mis.d",    dut_d(), 8'h80);
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b1);
      check_eq("mis.fv", {7'b0, bus.frame_valid}, 8'h01);
      check_eq("mis.d2", dut_d(), 8'hFE);

      // Slot-7 sync is misaligned: no publish
      for (int k = 0; k < 7; k++) step(1'b1, k == 0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check_eq("s7.err", {7'b0, bus.sync_err}, 8'h01);
      check_eq("s7.fv",  {7'b0, bus.frame_valid}, 8'h00);

      // Gaps inside a frame, then idle timeout
      for (int k = 0; k < 8; k++) begin
         logic [7:0] g;
         g = 8'hA5;
         step(1'b1, k == 0, g[k]);
         if (k != 7) for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0);
      end
      check_eq("gap.d", dut_d(), 8'hA5);
      for (int j = 0; j < 13; j++) step(1'b0, 1'b0, 1'b0);
      check_eq("idle.still_locked", {7'b0, bus.locked}, 8'h01);
      for (int j = 0; j < 2; j++) step(1'b0, 1'b0, 1'b0);
      check_eq("idle.unlocked", {7'b0, bus.locked}, 8'h00);
      check_eq("idle.d_kept",   dut_d(), 8'hA5);

      // Async reset mid-frame at slot 5
      send_frame(8'h3C);
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1);
      check_eq("ar.slot5", {5'b0, bus.s2, bus.s1, bus.s0}, 8'h05);
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("ar.d",      dut_d(), 8'h00);
      check_eq("ar.slot",   {5'b0, bus.s2, bus.s1, bus.s0}, 8'h00);
      check_eq("ar.locked", {7'b0, bus.locked}, 8'h00);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1);
      check_eq("ar.needs_sync", {7'b0, bus.locked}, 8'h00);
      send_frame(8'h96);
      check_eq("ar.new_frame", dut_d(), 8'h96);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            for (int j = 0; j < 16; j++) step(1'b0, 1'b0, 1'($urandom));
         end
         v = ($urandom_range(0, 3) != 0);
         if (frame_q.size() == 0) s = ($urandom_range(0, 7) != 0);
         else                     s = ($urandom_range(0, 31) == 0);
         step(v, s, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
